cpu_input_frontend: RTL and testbench

Input-side front end that produces the `din`, `gpi` and `gpi_hold` inputs consumed by the `cpu` block of the RPN calculator. It synchronises the raw board pushbuttons and slide switches, debounces button presses and releases, and issues exactly one single-cycle `gpi_hold` strobe per accepted press. The same edge that raises the strobe latches a stable operand byte and button code. It sits between the board pins and `cpu`, in the same clock domain as `cpu`.

---
 rtl/cpu_input_frontend_pkg.sv | 27 ++
 rtl/cpu_input_frontend_sync2.sv | 27 ++
 rtl/cpu_input_frontend.sv | 114 +++++++++++
 tb/tb_cpu_input_frontend.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_input_frontend_pkg.sv
// Shared types, FSM encodings and helpers for the CPU input front end.
// The 3-bit state codes are kept as macros so the cpu side can share them.
`ifndef CPU_DEFINITIONS_VH
`define CPU_DEFINITIONS_VH
`define IN_IDLE    3'd0
`define IN_ARM     3'd1
`define IN_PRESS   3'd2
`define IN_HELD    3'd3
`define IN_RELEASE 3'd4
`endif

package cpu_input_frontend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = `IN_IDLE,
        ST_ARM     = `IN_ARM,
        ST_PRESS   = `IN_PRESS,
        ST_HELD    = `IN_HELD,
        ST_RELEASE = `IN_RELEASE
    } in_state_e;

    // Isolates the lowest set bit, giving a one-hot code from a multi-button pattern.
    function automatic logic [3:0] lowest_set(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/cpu_input_frontend_sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
// Latency 2 cycles; no flow control.
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cpu_input_frontend.sv
// Synchronise and debounce buttons/switches, issue one gpi_hold strobe per accepted press.
// Strobe appears DEBOUNCE_CYCLES+2 edges after a clean press; no backpressure, cpu must sample the strobe.
module cpu_input_frontend
    import cpu_input_frontend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] btn_raw,
    input  logic [7:0] sw_raw,
    output logic [7:0] din,
    output logic [3:0] gpi,
    output logic       gpi_hold,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       btn_s;
    logic [7:0]       sw_s;
    in_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [7:0]       din_q, din_d;
    logic [3:0]       gpi_q, gpi_d;
    logic             hold_q, hold_d;
    logic             busy_q, busy_d;

    sync2 #(.W(4)) u_sync_btn (.clk(clk), .reset(reset), .d(btn_raw), .q(btn_s));
    sync2 #(.W(8)) u_sync_sw  (.clk(clk), .reset(reset), .d(sw_raw),  .q(sw_s));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        din_d   = din_q;
        gpi_d   = gpi_q;
        hold_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_s != 4'd0) begin
                    cand_d  = btn_s;
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (btn_s == 4'd0) begin
                    state_d = ST_IDLE;
                end else if (btn_s != cand_q) begin
                    cand_d = btn_s;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Press is consumed even when the cpu is disabled; only the strobe and latches are gated.
                    state_d = ST_PRESS;
                    hold_d  = enable;
                    if (enable) begin
                        gpi_d = lowest_set(cand_q);
                        din_d = sw_s;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PRESS: state_d = ST_HELD;
            ST_HELD: begin
                if (btn_s == 4'd0) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (btn_s != 4'd0) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            din_q   <= '0;
            gpi_q   <= '0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            din_q   <= din_d;
            gpi_q   <= gpi_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
        end
    end

    assign din      = din_q;
    assign gpi      = gpi_q;
    assign gpi_hold = hold_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_cpu_input_frontend.sv
// Randomized and directed bench for cpu_input_frontend against a run-length reference model.
module tb_cpu_input_frontend;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] btn_raw;
    logic [7:0] sw_raw;
    logic [7:0] din;
    logic [3:0] gpi;
    logic       gpi_hold;
    logic       busy;

    cpu_input_frontend #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .btn_raw(btn_raw), .sw_raw(sw_raw),
        .din(din), .gpi(gpi), .gpi_hold(gpi_hold), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: inputs reach the decision logic two edges late; a press is accepted
    // once one nonzero pattern is seen D+1 times in a row, the edge after acceptance is ignored,
    // and a new press is only considered after D+1 consecutive all-released samples.
    logic [3:0] m_b1, m_b2;
    logic [7:0] m_w1, m_w2;
    int         phase;      // 0 looking for press, 1 just accepted, 2 waiting for release
    logic [3:0] run_val;
    int         run_len;
    logic [7:0] exp_din;
    logic [3:0] exp_gpi;
    logic       exp_hold, exp_busy;

    task automatic model_clear();
        m_b1 = '0; m_b2 = '0; m_w1 = '0; m_w2 = '0;
        phase = 0; run_val = '0; run_len = 0;
        exp_din = '0; exp_gpi = '0; exp_hold = 1'b0; exp_busy = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] b;
        logic [7:0] w;
        if (reset) begin
            model_clear();
            return;
        end
        b = m_b2;
        w = m_w2;
        exp_hold = 1'b0;
        case (phase)
            0: begin
                if (b == 4'd0) begin
                    run_len = 0;
                end else begin
                    if (run_len > 0 && b == run_val) run_len++;
                    else begin
                        run_val = b;
                        run_len = 1;
                    end
                    if (run_len == D + 1) begin
                        if (enable) begin
                            exp_hold = 1'b1;
                            exp_din  = w;
                            exp_gpi  = '0;
                            for (int i = 3; i >= 0; i--) if (b[i]) exp_gpi = 4'(1 << i);
                        end
                        phase   = 1;
                        run_len = 0;
                    end
                end
            end
            1: begin
                phase   = 2;
                run_len = 0;
            end
            default: begin
                if (b == 4'd0) begin
                    run_len++;
                    if (run_len == D + 1) begin
                        phase   = 0;
                        run_len = 0;
                    end
                end else begin
                    run_len = 0;
                end
            end
        endcase
        exp_busy = (phase != 0) || (run_len > 0);
        m_b2 = m_b1; m_w2 = m_w1;
        m_b1 = btn_raw; m_w1 = sw_raw;
    endtask

    int edge_no = 0;
    int scn_start;
    int first_strb;
    int n_strb;

    task automatic begin_scn();
        scn_start  = edge_no;
        first_strb = -1;
        n_strb     = 0;
    endtask

    task automatic step(input int n);
        int cur;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            cur = edge_no;
            edge_no++;
            @(negedge clk);
            check_val("din", din, exp_din);
            check_val("gpi", gpi, exp_gpi);
            check_val("gpi_hold", gpi_hold, exp_hold);
            check_val("busy", busy, exp_busy);
            if (gpi_hold === 1'b1) begin
                if (first_strb < 0) first_strb = cur;
                n_strb++;
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_din"}, din, 8'h00);
        check_val({tag, "_gpi"}, gpi, 4'h0);
        check_val({tag, "_hold"}, gpi_hold, 1'b0);
        check_val({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; btn_raw = '0; sw_raw = '0;
        model_clear();
        #1;
        check_zero_outputs("reset");
        step(3);
        reset = 1'b0;

        // Clean press
        sw_raw = 8'hA5; btn_raw = 4'b0010;
        begin_scn();
        step(100);
        check_val("clean_edge", first_strb - scn_start, 18);
        check_val("clean_count", n_strb, 1);
        check_val("clean_gpi", gpi, 4'b0010);
        check_val("clean_din", din, 8'hA5);
        btn_raw = 4'b0000;
        step(10);
        check_val("clean_busy_release", busy, 1'b1);
        step(20);
        check_val("clean_busy_idle", busy, 1'b0);

        // Press bounce
        begin_scn();
        for (int k = 0; k < 10; k++) begin
            btn_raw = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            step(3);
        end
        btn_raw = 4'b0001;
        step(40);
        check_val("bounce_edge", first_strb - scn_start, 48);
        check_val("bounce_count", n_strb, 1);
        btn_raw = 4'b0000;
        step(30);

        // Multi-button and operand hold
        sw_raw = 8'hA5; btn_raw = 4'b1100;
        begin_scn();
        step(25);
        check_val("multi_gpi", gpi, 4'b0100);
        sw_raw = 8'h3C;
        step(10);
        check_val("multi_din_hold", din, 8'hA5);
        check_val("multi_count", n_strb, 1);
        btn_raw = 4'b0000;
        step(30);

        // Release bounce
        sw_raw = 8'hA5; btn_raw = 4'b0001;
        step(25);
        btn_raw = 4'b0000;
        step(10);
        btn_raw = 4'b0001;
        begin_scn();
        step(30);
        check_val("rebounce_no_strobe", n_strb, 0);
        btn_raw = 4'b0000;
        step(20);
        btn_raw = 4'b0001;
        begin_scn();
        step(30);
        check_val("second_press_edge", first_strb - scn_start, 18);
        btn_raw = 4'b0000;
        step(30);

        // Enable low
        enable = 1'b0; sw_raw = 8'hFF; btn_raw = 4'b0010;
        begin_scn();
        step(40);
        check_val("dis_count", n_strb, 0);
        check_val("dis_gpi", gpi, 4'b0001);
        check_val("dis_din", din, 8'hA5);
        check_val("dis_busy_held", busy, 1'b1);
        btn_raw = 4'b0000;
        step(30);
        enable = 1'b1;

        // Reset mid-ARM
        sw_raw = 8'h77; btn_raw = 4'b1000;
        begin_scn();
        step(10);
        reset = 1'b1;
        #1;
        model_clear();
        check_zero_outputs("midarm_reset");
        step(2);
        check_zero_outputs("midarm_held");
        reset = 1'b0;
        begin_scn();
        step(40);
        check_val("midarm_edge", first_strb - scn_start, 18);
        check_val("midarm_count", n_strb, 1);
        check_val("midarm_gpi", gpi, 4'b1000);
        check_val("midarm_din", din, 8'h77);
        btn_raw = 4'b0000;
        step(30);

        // Randomized segments
        for (int s = 0; s < 80; s++) begin
            btn_raw = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            sw_raw  = 8'($urandom_range(0, 255));
            enable  = ($urandom_range(0, 9) != 0);
            step($urandom_range(1, 40));
        end
        btn_raw = 4'b0000;
        step(40);
        check_val("final_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
